mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter: DATA_W, default 32, data width in bits.
REQ-003 SHALL have parameter: MEM_LATENCY, default 2, RAM read latency in cycles, legal range 1..15.
REQ-004 SHALL have port: clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: if_req  in  1  fetch request; if_addr  in  ADDR_W  fetch address.
REQ-007 SHALL have ports: if_ready  out  1  fetch-done pulse; if_rdata  out  DATA_W  fetched word.
REQ-008 SHALL have ports: mem_req  in  1  load/store request; mem_we  in  1  store when 1; mem_addr  in  ADDR_W  data address; mem_wdata  in  DATA_W  store data.
REQ-009 SHALL have ports: mem_ready  out  1  load/store-done pulse; mem_rdata  out  DATA_W  loaded word.
REQ-010 SHALL have ports: ram_en  out  1  RAM access strobe; ram_we  out  1  RAM write; ram_addr  out  ADDR_W; ram_wdata  out  DATA_W; ram_rdata  in  DATA_W.
REQ-011 SHALL have ports: if_stall  out  1  (if_req and not if_ready); mem_stall  out  1  (mem_req and not mem_ready).

Function
REQ-012 SHALL implement states IDLE, WAIT and DONE; all outputs except the stall ports SHALL be registered.
REQ-013 SHALL, in IDLE with any request, grant one requester at edge k, drive ram_en, ram_we, ram_addr and ram_wdata from that requester for exactly cycle k..k+1, load a latency counter with MEM_LATENCY, and enter WAIT.
REQ-014 SHALL, in WAIT, decrement the counter each cycle; at edge k+1+MEM_LATENCY it SHALL capture ram_rdata into the granted requester's rdata and pulse that requester's ready for exactly one cycle (DONE).
REQ-015 SHALL go from DONE to IDLE unconditionally; the earliest next grant is the edge ending DONE.
REQ-016 SHALL give stores the same timing as loads; mem_rdata SHALL be left unchanged on a store.
REQ-017 SHALL, by default, give mem_req fixed priority over if_req when both are asserted in IDLE.
REQ-018 SHALL require requesters to hold req, addr, we and wdata stable until ready; a request dropped mid-access SHALL still complete and pulse ready.
REQ-019 SHALL never pulse if_ready and mem_ready in the same cycle, and SHALL never assert ram_en outside the grant cycle.
REQ-020 SHALL keep if_rdata and mem_rdata holding their last captured value between accesses.

Reset
REQ-021 SHALL, while reset is low, force state IDLE, counter 0, every output and every rdata register to 0, and clear the round-robin pointer to "MEM last".
REQ-022 SHALL abandon any in-flight access on reset, with no ready pulse after release.

Configuration
REQ-023 SHALL support macro MEM_ARBITER_RR_EN; when defined, arbitration is round-robin: on a tie, the requester not granted last wins, and the pointer updates on every grant.
REQ-024 SHALL use fixed MEM priority (REQ-017) when MEM_ARBITER_RR_EN is undefined, with no pointer register present.

Structure
REQ-025 SHALL take the state enum, requester-id encoding and default widths from the shared package mips_pkg.
REQ-026 SHALL be a single module; no sub-module is needed.

Verification
REQ-027 SHALL cover: lone fetch if_req=1, if_addr=0x10, RAM returns 0x2002000D -> ram_en at edge k, if_ready at edge k+3 (MEM_LATENCY=2), if_rdata=0x2002000D.
REQ-028 SHALL cover: simultaneous if_req and mem_req (load 0x40) -> MEM granted first, mem_ready at k+3; IF granted at k+4, if_ready at k+7.
REQ-029 SHALL cover: store mem_we=1, addr 0x44, wdata 23 -> ram_we=1 for one cycle with ram_wdata=23, mem_ready at k+3, mem_rdata unchanged.
REQ-030 SHALL cover: with MEM_ARBITER_RR_EN defined, both requesters continuously asserted for 4 accesses -> grants alternate IF, MEM, IF, MEM.
REQ-031 SHALL cover: reset low at k+1 during a fetch -> all outputs 0 immediately; no if_ready after release; a new fetch completes normally.
REQ-032 SHALL cover: MEM_LATENCY=1 and MEM_LATENCY=15 -> ready at k+2 and k+16 respectively.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// FSM encoding, requester ids and default widths.
package mips_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MEM_LATENCY = 2;
  localparam int LAT_CNT_W       = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, load/store port and RAM port seen by the memory arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface mem_arbiter_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_ready, if_rdata, if_stall, mem_ready, mem_rdata, mem_stall,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_ready, if_rdata, if_stall, mem_ready, mem_rdata, mem_stall,
           ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of a single-port RAM with fixed read latency.
// Build macro MEM_ARBITER_RR_EN: round-robin on ties instead of fixed load/store priority.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  // state | meaning
  // IDLE  | no access in flight
  // WAIT  | RAM strobed, down-counting the read latency
  // DONE  | ready pulsed to the granted requester; next grant may happen here

  localparam logic [LAT_CNT_W-1:0] LAT = LAT_CNT_W'(MEM_LATENCY);

  logic [1:0]           state;
  logic [LAT_CNT_W-1:0] cnt;
  req_id_t              gnt_id;
  logic                 gnt_we;
  logic                 if_ready_q;
  logic                 mem_ready_q;
  logic                 ram_en_q;
  logic                 ram_we_q;
  logic [DATA_W-1:0]    if_rdata_q;
  logic [DATA_W-1:0]    mem_rdata_q;
  logic [DATA_W-1:0]    ram_wdata_q;
  logic [ADDR_W-1:0]    ram_addr_q;
  logic                 if_want;
  logic                 mem_want;
  logic                 can_grant;
  logic                 pick_mem;

  // The requester being answered this cycle does not compete for the next grant.
  assign if_want   = bus.if_req & ~if_ready_q;
  assign mem_want  = bus.mem_req & ~mem_ready_q;
  assign can_grant = ((state == ST_IDLE) || (state == ST_DONE)) && (if_want || mem_want);

`ifdef MEM_ARBITER_RR_EN
  logic last_mem;

  assign pick_mem = mem_want && (!if_want || !last_mem);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_mem <= 1'b1;
    end else if (can_grant) begin
      last_mem <= pick_mem;
    end
  end
`else
  assign pick_mem = mem_want;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      gnt_id      <= REQ_IF;
      gnt_we      <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      ram_wdata_q <= '0;
      ram_addr_q  <= '0;
    end else begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if (state == ST_WAIT) begin
        if (cnt == '0) begin
          state <= ST_DONE;
          if (gnt_id == REQ_MEM) begin
            mem_ready_q <= 1'b1;
            if (!gnt_we) begin
              mem_rdata_q <= bus.ram_rdata;
            end
          end else begin
            if_ready_q <= 1'b1;
            if_rdata_q <= bus.ram_rdata;
          end
        end else begin
          cnt <= cnt - LAT_CNT_W'(1);
        end
      end else if (can_grant) begin
        state       <= ST_WAIT;
        cnt         <= LAT;
        ram_en_q    <= 1'b1;
        gnt_id      <= pick_mem ? REQ_MEM : REQ_IF;
        gnt_we      <= pick_mem & bus.mem_we;
        ram_we_q    <= pick_mem & bus.mem_we;
        ram_addr_q  <= pick_mem ? bus.mem_addr : bus.if_addr;
        ram_wdata_q <= pick_mem ? bus.mem_wdata : '0;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_stall  = bus.if_req & ~if_ready_q;
  assign bus.mem_stall = bus.mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of lone accesses plus hand-written
// sequences for contention, reset mid-access and latency extremes.
module tb_mem_arbiter;
  import mips_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARBITER_RR_EN
  localparam bit FIRST_MEM = 1'b0;
`else
  localparam bit FIRST_MEM = 1'b1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b15 ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut_l1 (
    .clock(clock), .reset(reset), .bus(b1));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(15)) dut_l15 (
    .clock(clock), .reset(reset), .bus(b15));

  typedef struct {
    logic          is_mem;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] ram_val;
    logic          exp_ram_we;
    logic [DW-1:0] exp_ram_wdata;
    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_mem_rdata;
  } vec_t;

  vec_t vecs[6];
  vec_t vr;
  int   errors = 0;
  int   checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Lone access at MEM_LATENCY=2; called at #1 after an edge with the DUT idle.
  task automatic run_vec(input vec_t v, input string tag);
    if (v.is_mem) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = v.we;
      bus.mem_addr  = v.addr;
      bus.mem_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    bus.ram_rdata = ~v.ram_val;
    #1;
    chk1({tag, "_stall_pre"}, v.is_mem ? bus.mem_stall : bus.if_stall, 1'b1);
    step();
    chk1({tag, "_en_k"}, bus.ram_en, 1'b1);
    chk1({tag, "_we_k"}, bus.ram_we, v.exp_ram_we);
    chk32({tag, "_addr_k"}, bus.ram_addr, v.addr);
    chk32({tag, "_wdata_k"}, bus.ram_wdata, v.exp_ram_wdata);
    step();
    chk1({tag, "_en_k1"}, bus.ram_en, 1'b0);
    chk1({tag, "_we_k1"}, bus.ram_we, 1'b0);
    step();
    bus.ram_rdata = v.ram_val;
    chk1({tag, "_ready_k2"}, bus.if_ready | bus.mem_ready, 1'b0);
    step();
    bus.ram_rdata = ~v.ram_val;
    chk1({tag, "_if_ready_k3"}, bus.if_ready, ~v.is_mem);
    chk1({tag, "_mem_ready_k3"}, bus.mem_ready, v.is_mem);
    chk32({tag, "_if_rdata_k3"}, bus.if_rdata, v.exp_if_rdata);
    chk32({tag, "_mem_rdata_k3"}, bus.mem_rdata, v.exp_mem_rdata);
    chk1({tag, "_stall_k3"}, v.is_mem ? bus.mem_stall : bus.if_stall, 1'b0);
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    step();
    chk1({tag, "_ready_k4"}, bus.if_ready | bus.mem_ready, 1'b0);
    chk1({tag, "_en_k4"}, bus.ram_en, 1'b0);
    chk32({tag, "_if_hold"}, bus.if_rdata, v.exp_if_rdata);
    chk32({tag, "_mem_hold"}, bus.mem_rdata, v.exp_mem_rdata);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_en"}, bus.ram_en, 1'b0);
    chk1({tag, "_we"}, bus.ram_we, 1'b0);
    chk32({tag, "_addr"}, bus.ram_addr, 32'h0);
    chk32({tag, "_wdata"}, bus.ram_wdata, 32'h0);
    chk1({tag, "_if_ready"}, bus.if_ready, 1'b0);
    chk1({tag, "_mem_ready"}, bus.mem_ready, 1'b0);
    chk32({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
    chk32({tag, "_mem_rdata"}, bus.mem_rdata, 32'h0);
  endtask

  initial begin
    //          mem we  addr           wdata   ram_val        rwe rwdata  if_rdata       mem_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h10,       32'd0,  32'h2002000D, 1'b0, 32'd0,  32'h2002000D, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h40,       32'd0,  32'h8C010004, 1'b0, 32'd0,  32'h2002000D, 32'h8C010004};
    vecs[2] = '{1'b1, 1'b1, 32'h44,       32'd23, 32'hFFFFFFFF, 1'b1, 32'd23, 32'h2002000D, 32'h8C010004};
    vecs[3] = '{1'b0, 1'b0, 32'h14,       32'd0,  32'hAC020044, 1'b0, 32'd0,  32'hAC020044, 32'h8C010004};
    vecs[4] = '{1'b1, 1'b0, 32'h48,       32'd0,  32'h00000001, 1'b0, 32'd0,  32'hAC020044, 32'h00000001};
    vecs[5] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'd0,  32'h12345678, 1'b0, 32'd0,  32'h12345678, 32'h00000001};

    bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.ram_rdata = '0;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.mem_req = 1'b0; b1.mem_we = 1'b0;
    b1.mem_addr = '0; b1.mem_wdata = '0; b1.ram_rdata = '0;
    b15.if_req = 1'b0; b15.if_addr = '0; b15.mem_req = 1'b0; b15.mem_we = 1'b0;
    b15.mem_addr = '0; b15.mem_wdata = '0; b15.ram_rdata = '0;

    step();
    step();
    chk_all_zero("reset");
    chk1("reset_if_stall", bus.if_stall, 1'b0);
    chk1("reset_mem_stall", bus.mem_stall, 1'b0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous fetch 0x20 and load 0x40: load first, fetch granted at the edge ending DONE.
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h40;
    bus.ram_rdata = 32'h0;
    step();
    chk1("both_en_k", bus.ram_en, 1'b1);
    chk32("both_addr_k", bus.ram_addr, 32'h40);
    chk1("both_if_stall_k", bus.if_stall, 1'b1);
    step();
    step();
    bus.ram_rdata = 32'hCAFE0040;
    step();
    bus.ram_rdata = 32'h0;
    chk1("both_mem_ready_k3", bus.mem_ready, 1'b1);
    chk1("both_if_ready_k3", bus.if_ready, 1'b0);
    chk32("both_mem_rdata_k3", bus.mem_rdata, 32'hCAFE0040);
    chk1("both_if_stall_k3", bus.if_stall, 1'b1);
    chk1("both_mem_stall_k3", bus.mem_stall, 1'b0);
    bus.mem_req = 1'b0;
    step();
    chk1("both_en_k4", bus.ram_en, 1'b1);
    chk32("both_addr_k4", bus.ram_addr, 32'h20);
    chk1("both_mem_ready_k4", bus.mem_ready, 1'b0);
    step();
    chk1("both_en_k5", bus.ram_en, 1'b0);
    step();
    bus.ram_rdata = 32'hBEEF0020;
    step();
    bus.ram_rdata = 32'h0;
    chk1("both_if_ready_k7", bus.if_ready, 1'b1);
    chk1("both_mem_ready_k7", bus.mem_ready, 1'b0);
    chk32("both_if_rdata_k7", bus.if_rdata, 32'hBEEF0020);
    chk32("both_mem_rdata_k7", bus.mem_rdata, 32'hCAFE0040);
    bus.if_req = 1'b0;
    step();
    chk1("both_if_ready_k8", bus.if_ready, 1'b0);
    chk1("both_en_k8", bus.ram_en, 1'b0);

    // Reset asserted one cycle into a fetch.
    bus.if_req = 1'b1; bus.if_addr = 32'h30; bus.ram_rdata = 32'h55555555;
    step();
    chk1("rst_en_k", bus.ram_en, 1'b1);
    step();
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    bus.if_req = 1'b0;
    step();
    step();
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      chk1("rst_no_ready", bus.if_ready, 1'b0);
      chk1("rst_no_en", bus.ram_en, 1'b0);
    end
    vr = '{1'b0, 1'b0, 32'h34, 32'd0, 32'h0BADF00D, 1'b0, 32'd0, 32'h0BADF00D, 32'h0};
    run_vec(vr, "post_rst");

    // Both requesters held through four accesses; pointer starts at "MEM last".
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h200;
    bus.ram_rdata = 32'h0;
    for (int n = 0; n < 16; n++) begin
      bit sm;
      step();
      sm = (FIRST_MEM != (((n / 4) % 2) == 1));
      chk1("cont_en", bus.ram_en, (n % 4) == 0);
      if ((n % 4) == 0) begin
        chk32("cont_grant_addr", bus.ram_addr, sm ? 32'h200 : 32'h100);
      end
      chk1("cont_mem_ready", bus.mem_ready, ((n % 4) == 3) && sm);
      chk1("cont_if_ready", bus.if_ready, ((n % 4) == 3) && !sm);
    end
    bus.if_req = 1'b0;
    bus.mem_req = 1'b0;
    step();
    chk1("cont_end_en", bus.ram_en, 1'b0);

    // Latency extremes on the side instances, one lone fetch each.
    b1.if_req = 1'b1; b1.if_addr = 32'h50; b1.ram_rdata = ~32'h11110001;
    b15.if_req = 1'b1; b15.if_addr = 32'h60; b15.ram_rdata = ~32'h1515000F;
    for (int n = 0; n < 18; n++) begin
      step();
      chk1("l1_en", b1.ram_en, n == 0);
      chk1("l15_en", b15.ram_en, n == 0);
      chk1("l1_ready", b1.if_ready, n == 2);
      chk1("l15_ready", b15.if_ready, n == 16);
      if (n == 2) begin
        chk32("l1_rdata", b1.if_rdata, 32'h11110001);
        b1.if_req = 1'b0;
      end
      if (n == 16) begin
        chk32("l15_rdata", b15.if_rdata, 32'h1515000F);
        b15.if_req = 1'b0;
      end
      b1.ram_rdata  = (n == 1)  ? 32'h11110001 : ~32'h11110001;
      b15.ram_rdata = (n == 15) ? 32'h1515000F : ~32'h1515000F;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
